// File: rtl/scene_scan.sv
// rtl/scene_scan.sv - 640x480 scan generator with wall-map lookup and tank sprite classification
//
// Purpose: divides clk_100mhz by four into pixel ticks, walks an 800x525
// raster (visible area plus front porch, sync and back porch), fetches the
// 32x32 wall tile under the current pixel from an external map RAM and
// classifies every pixel as NONE, WALL or TANK for the colour stage.
//
// Ports:
//   clk_100mhz  - system clock, all registers on its rising edge
//   rst_n       - asynchronous active-low reset
//   tank_x/y    - tank sprite top-left column/row, sampled once per frame
//   map_addr    - tile address to the wall map RAM (20 tiles per row)
//   map_data    - wall bit returned by the RAM one clock after map_addr
//   category    - pixel class: 0 NONE, 1 WALL, 2 TANK
//   hsync/vsync - active-low sync pulses
//   video_on    - high while the displayed pixel is in the visible area
//   frame_start - one-clock pulse when the raster returns to pixel (0,0)
//
// The porch/sync parameters default to the standard 640x480 timing; they
// exist so the same raster logic can be exercised on a reduced geometry.
module scene_scan #(
  parameter int H_VIS   = 640,
  parameter int V_VIS   = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  output logic [8:0] map_addr,
  input  logic       map_data,
  output logic [3:0] category,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIS + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FRONT + V_SYNC - 1);

  localparam logic [3:0] CAT_NONE = 4'd0;
  localparam logic [3:0] CAT_WALL = 4'd1;
  localparam logic [3:0] CAT_TANK = 4'd2;

  logic [1:0] d;
  logic [9:0] h;
  logic [9:0] v;
  logic [9:0] tx;
  logic [9:0] ty;

  logic tick;
  logic line_end;
  logic frame_end;
  logic visible;
  logic in_hsync;
  logic in_vsync;
  logic in_tank;

  // Tank box compared one bit wider than the counters so tx+31 cannot wrap
  // back into low columns when the tank sits near the right/bottom edge.
  logic [10:0] h_w;
  logic [10:0] v_w;
  logic [10:0] tx_w;
  logic [10:0] ty_w;

  assign tick      = (d == 2'd3);
  assign line_end  = (h == H_LAST);
  assign frame_end = line_end && (v == V_LAST);
  assign visible   = (h < H_VIS_W) && (v < V_VIS_W);
  assign in_hsync  = (h >= HS_FIRST) && (h <= HS_LAST);
  assign in_vsync  = (v >= VS_FIRST) && (v <= VS_LAST);

  assign h_w  = {1'b0, h};
  assign v_w  = {1'b0, v};
  assign tx_w = {1'b0, tx};
  assign ty_w = {1'b0, ty};
  assign in_tank = (h_w >= tx_w) && (h_w <= tx_w + 11'd31) &&
                   (v_w >= ty_w) && (v_w <= ty_w + 11'd31);

  // Address is presented during phases 0..1 of a pixel so the RAM answer is
  // already on map_data at the phase-1 edge where the class is registered.
  always_comb begin
    map_addr = 9'd0;
    if (visible) begin
      map_addr = 9'(v[9:5]) * 9'd20 + 9'(h[9:5]);
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      d           <= 2'd0;
      h           <= 10'd0;
      v           <= 10'd0;
      tx          <= 10'd0;
      ty          <= 10'd0;
      category    <= CAT_NONE;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      d           <= d + 2'd1;
      frame_start <= 1'b0;

      if (tick) begin
        if (line_end) begin
          h <= 10'd0;
          v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
        // Sprite position is frozen for the whole frame to avoid tearing.
        if (frame_end) begin
          tx          <= tank_x;
          ty          <= tank_y;
          frame_start <= 1'b1;
        end
      end

      if (d == 2'd1) begin
        video_on <= visible;
        hsync    <= !in_hsync;
        vsync    <= !in_vsync;
        if (!visible) begin
          category <= CAT_NONE;
        end else if (in_tank) begin
          category <= CAT_TANK;
        end else if (map_data) begin
          category <= CAT_WALL;
        end else begin
          category <= CAT_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_scene_scan.sv
// tb/tb_scene_scan.sv - self-checking bench for scene_scan against a raster-position model
module tb_scene_scan;

  // Reduced raster: 112 x 70 pixels, 96 x 64 visible.
  localparam int S_HV = 96, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VV = 64, S_VF = 2, S_VS = 2, S_VB = 2;
  localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);
  // Full 640x480 raster.
  localparam int F_HV = 640, F_HF = 16, F_HS = 96, F_HB = 48;
  localparam int F_VV = 480, F_VF = 10, F_VS = 2, F_VB = 33;
  localparam int F_FRAME = 800 * 525;

  logic       clk_100mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] tank_x = 10'd0;
  logic [9:0] tank_y = 10'd0;

  logic [8:0] s_map_addr, f_map_addr;
  logic       s_map_data = 1'b0, f_map_data = 1'b0;
  logic [3:0] s_category, f_category;
  logic       s_hsync, s_vsync, s_video_on, s_frame_start;
  logic       f_hsync, f_vsync, f_video_on, f_frame_start;

  logic wall_map [0:511];

  int  k = 0;
  int  mtx_s = 0, mty_s = 0, mtx_f = 0, mty_f = 0;
  int  checks = 0;
  int  errors = 0;
  logic finish_req = 1'b0;

  always #5 clk_100mhz = ~clk_100mhz;

  scene_scan #(
    .H_VIS(S_HV), .V_VIS(S_VV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) dut_small (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n), .tank_x(tank_x), .tank_y(tank_y),
    .map_addr(s_map_addr), .map_data(s_map_data), .category(s_category),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on), .frame_start(s_frame_start)
  );

  scene_scan dut_full (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n), .tank_x(tank_x), .tank_y(tank_y),
    .map_addr(f_map_addr), .map_data(f_map_data), .category(f_category),
    .hsync(f_hsync), .vsync(f_vsync), .video_on(f_video_on), .frame_start(f_frame_start)
  );

  // Synchronous-read wall RAMs, one per instance.
  always @(posedge clk_100mhz) begin
    s_map_data <= wall_map[s_map_addr];
    f_map_data <= wall_map[f_map_addr];
  end

  // Reference timeline: k counts clock edges since reset release; the
  // sprite position of each frame is whatever tank_x/y held on the last
  // edge of the previous frame.
  always @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      mtx_s <= 0; mty_s <= 0; mtx_f <= 0; mty_f <= 0;
    end else begin
      if (k % 4 == 3 && (k / 4) % S_FRAME == S_FRAME - 1) begin
        mtx_s <= int'(tank_x); mty_s <= int'(tank_y);
      end
      if (k % 4 == 3 && (k / 4) % F_FRAME == F_FRAME - 1) begin
        mtx_f <= int'(tank_x); mty_f <= int'(tank_y);
      end
      k <= k + 1;
    end
  end

  // Expected {map_addr, category, hsync, vsync, video_on, frame_start}
  // after k edges: counters show pixel k/4, registered outputs show the
  // pixel that was current at the most recent edge with k%4 == 2.
  function automatic logic [16:0] expect_outs(input int kk,
      input int hv, input int hf, input int hs, input int hb,
      input int vv, input int vf, input int vs, input int vb,
      input int tx, input int ty);
    int ht, vt, fr, p, h, v, q, qh, qv;
    logic [8:0] addr;
    logic [3:0] cat;
    logic hsn, vsn, von, fs;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    fr = ht * vt;
    p = (kk / 4) % fr;
    h = p % ht;
    v = p / ht;
    addr = (h < hv && v < vv) ? 9'((v / 32) * 20 + h / 32) : 9'd0;
    fs = (kk > 0 && kk % 4 == 0 && p == 0);
    if (kk < 2) begin
      cat = 4'd0; hsn = 1'b1; vsn = 1'b1; von = 1'b0;
    end else begin
      q = ((kk - ((kk - 2) % 4) - 1) / 4) % fr;
      qh = q % ht;
      qv = q / ht;
      von = (qh < hv && qv < vv);
      hsn = !(qh >= hv + hf && qh < hv + hf + hs);
      vsn = !(qv >= vv + vf && qv < vv + vf + vs);
      if (!von) cat = 4'd0;
      else if (qh >= tx && qh <= tx + 31 && qv >= ty && qv <= ty + 31) cat = 4'd2;
      else if (wall_map[(qv / 32) * 20 + qh / 32]) cat = 4'd1;
      else cat = 4'd0;
    end
    return {addr, cat, hsn, vsn, von, fs};
  endfunction

  // Hand-computed per-frame totals on the reduced raster (clocks).
  int exp_wall [2] = '{8192, 8192};
  int exp_tank [2] = '{4096, 96};

  logic [16:0] es, as_s, ef, as_f;
  int win = 0, fs_total = 0, f_fs_total = 0;
  int wall_cnt = 0, tank_cnt = 0, hs_cnt = 0, vs_cnt = 0;
  int f_hs_cnt = 0;
  logic f_hs_done = 1'b0;

  always begin
    @(negedge clk_100mhz or negedge rst_n);
    #1;
    es   = expect_outs(k, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, mtx_s, mty_s);
    as_s = {s_map_addr, s_category, s_hsync, s_vsync, s_video_on, s_frame_start};
    checks++;
    if (as_s !== es) begin
      errors++;
      $display("FAIL small_outputs k=%0d got %h want %h", k, as_s, es);
    end
    ef   = expect_outs(k, F_HV, F_HF, F_HS, F_HB, F_VV, F_VF, F_VS, F_VB, mtx_f, mty_f);
    as_f = {f_map_addr, f_category, f_hsync, f_vsync, f_video_on, f_frame_start};
    checks++;
    if (as_f !== ef) begin
      errors++;
      $display("FAIL full_outputs k=%0d got %h want %h", k, as_f, ef);
    end

    if (!rst_n) begin
      win = 0; wall_cnt = 0; tank_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    end else begin
      if (f_frame_start) f_fs_total++;
      if (s_frame_start) begin
        fs_total++;
        if (win < 2) begin
          checks++;
          if (k != S_FRAME * 4 * (win + 1)) begin
            errors++;
            $display("FAIL frame_period win=%0d got %0d want %0d", win, k, S_FRAME * 4 * (win + 1));
          end
          checks++;
          if (wall_cnt != exp_wall[win]) begin
            errors++;
            $display("FAIL wall_clocks win=%0d got %0d want %0d", win, wall_cnt, exp_wall[win]);
          end
          checks++;
          if (tank_cnt != exp_tank[win]) begin
            errors++;
            $display("FAIL tank_clocks win=%0d got %0d want %0d", win, tank_cnt, exp_tank[win]);
          end
          checks++;
          if (hs_cnt != 2240) begin
            errors++;
            $display("FAIL hsync_low_clocks win=%0d got %0d want 2240", win, hs_cnt);
          end
          checks++;
          if (vs_cnt != 896) begin
            errors++;
            $display("FAIL vsync_low_clocks win=%0d got %0d want 896", win, vs_cnt);
          end
        end
        win++;
        wall_cnt = 0; tank_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      end
      if (s_category == 4'd1) wall_cnt++;
      if (s_category == 4'd2) tank_cnt++;
      if (!s_hsync) hs_cnt++;
      if (!s_vsync) vs_cnt++;

      // Full raster: three lines carry 3 * 96 pixels * 4 clocks of hsync.
      if (k < 9600) begin
        if (!f_hsync) f_hs_cnt++;
      end else if (!f_hs_done) begin
        f_hs_done = 1'b1;
        checks++;
        if (f_hs_cnt != 1152) begin
          errors++;
          $display("FAIL full_hsync_3lines got %0d want 1152", f_hs_cnt);
        end
      end
    end

    if (finish_req) begin
      checks++;
      if (fs_total != 2) begin
        errors++;
        $display("FAIL small_frame_starts got %0d want 2", fs_total);
      end
      checks++;
      if (f_fs_total != 0) begin
        errors++;
        $display("FAIL full_frame_starts got %0d want 0", f_fs_total);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic random_tank();
    int sx, sy;
    sx = int'($urandom_range(0, 3));
    sy = int'($urandom_range(0, 3));
    tank_x = (sx == 0) ? 10'($urandom_range(0, 127)) : (sx == 1) ? 10'($urandom_range(0, 1023)) :
             (sx == 2) ? 10'd90 : 10'd1023;
    tank_y = (sy == 0) ? 10'($urandom_range(0, 95)) : (sy == 1) ? 10'($urandom_range(0, 1023)) :
             (sy == 2) ? 10'd60 : 10'd1023;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) wall_map[i] = 1'b0;
    wall_map[2]  = 1'b1;
    wall_map[21] = 1'b1;
    wall_map[5]  = 1'b1;
    wall_map[10] = 1'b1;
    wall_map[27] = 1'b1;

    repeat (5) @(negedge clk_100mhz);
    rst_n = 1'b1;

    for (int c = 1; c <= 74720; c++) begin
      @(negedge clk_100mhz);
      if (c == 30000) begin
        tank_x = 10'd90; tank_y = 10'd60;     // right/bottom edge clip
      end else if (c == 61000) begin
        tank_x = 10'd33; tank_y = 10'd40;     // over wall tile 21
      end else if (!(c >= 30000 && c < 31400) && !(c >= 61000 && c < 62760) &&
                   $urandom_range(0, 999) == 0) begin
        random_tank();
      end
    end

    // Mid-frame asynchronous reset away from any clock edge.
    @(posedge clk_100mhz);
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk_100mhz);
    finish_req = 1'b1;

    repeat (5) @(negedge clk_100mhz);
    $display("FAIL summary_not_reached");
    $fatal(1);
  end

endmodule
